// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit with a valid/ready handshake.
// Multiply is shift-add (or one-cycle when MUL_SEQ=0); divide is restoring radix-2.
// Divide-by-zero, signed overflow and illegal ops skip CALC and go straight to DONE.
module mdu_iter #(
    parameter int XLEN    = 64,
    parameter int MUL_SEQ = 1,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]   MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ONE  = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2 = (2*XLEN)'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;    // product accumulator / remainder in low half
    logic [2*XLEN-1:0]   opa_q, opa_d;    // multiplicand (shifts left) / divisor in low half
    logic [XLEN-1:0]     opb_q, opb_d;    // multiplier (shifts right) / dividend->quotient
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;    // negate product or quotient at the end
    logic                negrem_q, negrem_d;
    logic [XLEN-1:0]     res_q, res_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Accept-side decode: operand magnitudes, signs, special cases, iteration count.
    logic            dec_w, dec_div, dec_s1, dec_s2, dec_illegal, dec_bypass;
    logic            dec_neg1, dec_neg2, dec_dz, dec_ovf;
    logic [31:0]     neg1_32, neg2_32;
    logic [XLEN-1:0] neg1_x, neg2_x, mag1, mag2, sx1, byp_res;
    logic [CW-1:0]   dec_k;

    // Decode the incoming request into magnitudes and bypass results.
    always_comb begin
        dec_w       = (XLEN == 64) && in_op[3];
        dec_illegal = (in_op[3] && (XLEN != 64)) || (in_op inside {4'd9, 4'd10, 4'd11});
        dec_div     = in_op[2];
        dec_s1      = in_op[2:0] inside {3'd1, 3'd2, 3'd4, 3'd6};
        dec_s2      = in_op[2:0] inside {3'd1, 3'd4, 3'd6};
        neg1_32     = ~in_src1[31:0] + 32'd1;
        neg2_32     = ~in_src2[31:0] + 32'd1;
        neg1_x      = ~in_src1 + ONE;
        neg2_x      = ~in_src2 + ONE;
        if (dec_w) begin
            dec_neg1 = dec_s1 && in_src1[31];
            dec_neg2 = dec_s2 && in_src2[31];
            mag1     = dec_neg1 ? XLEN'(neg1_32) : XLEN'(in_src1[31:0]);
            mag2     = dec_neg2 ? XLEN'(neg2_32) : XLEN'(in_src2[31:0]);
            sx1      = sext32(in_src1[31:0]);
            dec_dz   = dec_div && (in_src2[31:0] == 32'd0);
            dec_ovf  = dec_div && dec_s1 && (in_src1[31:0] == 32'h8000_0000)
                       && (in_src2[31:0] == 32'hFFFF_FFFF);
            dec_k    = CW'(32);
        end else begin
            dec_neg1 = dec_s1 && in_src1[XLEN-1];
            dec_neg2 = dec_s2 && in_src2[XLEN-1];
            mag1     = dec_neg1 ? neg1_x : in_src1;
            mag2     = dec_neg2 ? neg2_x : in_src2;
            sx1      = in_src1;
            dec_dz   = dec_div && (in_src2 == '0);
            dec_ovf  = dec_div && dec_s1 && (in_src1 == MINV) && (in_src2 == '1);
            dec_k    = CW'(XLEN);
        end
        if (!dec_div && (MUL_SEQ == 0)) dec_k = CW'(1);
        dec_bypass = dec_illegal || dec_dz || dec_ovf;
        byp_res    = '0;
        if (dec_illegal)  byp_res = '0;
        else if (dec_dz)  byp_res = in_op[1] ? sx1 : '1;
        else if (dec_ovf) byp_res = in_op[1] ? '0 : sx1;
    end

    // One CALC step plus the sign-corrected result it would produce if it were the last.
    logic              is_w_q;
    logic [2*XLEN-1:0] opb_wide, acc_n, opa_n, prod;
    logic [XLEN:0]     rs, diff;
    logic [XLEN-1:0]   rem_n, quo_n, opb_n, quo_s, rem_s, sel_s, fin_res;

    // Iteration datapath shared by multiply and divide.
    always_comb begin
        is_w_q   = (XLEN == 64) && op_q[3];
        opb_wide = (2*XLEN)'(opb_q);
        rs       = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
        diff     = rs - {1'b0, opa_q[XLEN-1:0]};
        rem_n    = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
        quo_n    = {opb_q[XLEN-2:0], ~diff[XLEN]};
        if (op_q[2]) begin
            acc_n = (2*XLEN)'(rem_n);
            opa_n = opa_q;
            opb_n = quo_n;
        end else begin
            if (MUL_SEQ != 0) acc_n = acc_q + (opb_q[0] ? opa_q : '0);
            else              acc_n = opa_q * opb_wide;
            opa_n = opa_q << 1;
            opb_n = opb_q >> 1;
        end
        prod  = neg_q ? (~acc_n + ONE2) : acc_n;
        quo_s = neg_q ? (~quo_n + ONE) : quo_n;
        rem_s = negrem_q ? (~rem_n + ONE) : rem_n;
        if (op_q[2])               sel_s = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'd0) sel_s = prod[XLEN-1:0];
        else                       sel_s = prod[2*XLEN-1:XLEN];
        fin_res = is_w_q ? sext32(sel_s[31:0]) : sel_s;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        negrem_d = negrem_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d     = in_op;
                    tag_d    = in_tag;
                    neg_d    = dec_neg1 ^ dec_neg2;
                    negrem_d = dec_neg1;
                    acc_d    = '0;
                    cnt_d    = dec_k;
                    if (dec_div) begin
                        // W dividends sit in the top half so the divider always consumes from the MSB.
                        opa_d = (2*XLEN)'(mag2);
                        opb_d = dec_w ? (mag1 << 32) : mag1;
                    end else begin
                        opa_d = (2*XLEN)'(mag1);
                        opb_d = mag2;
                    end
                    if (dec_bypass) begin
                        res_d   = byp_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_n;
                opa_d = opa_n;
                opb_d = opb_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = fin_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            negrem_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            negrem_q <= negrem_d;
            res_q    <= res_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus random ops against an arithmetic reference.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_op = '0;
    logic [63:0] src1 = '0, src2 = '0;
    logic [4:0]  in_tag = '0;
    int unsigned sel = 0;

    logic        iv0, iv1, or0, or1;
    logic        ir0, ir1, ov0, ov1, bz0, bz1;
    logic [63:0] res0, res1;
    logic [4:0]  tg0, tg1;
    logic        obs_ready, obs_valid, obs_busy;
    logic [63:0] obs_res;
    logic [4:0]  obs_tag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign or0 = out_ready && (sel == 0);
    assign or1 = out_ready && (sel == 1);
    assign obs_ready = (sel == 1) ? ir1 : ir0;
    assign obs_valid = (sel == 1) ? ov1 : ov0;
    assign obs_busy  = (sel == 1) ? bz1 : bz0;
    assign obs_res   = (sel == 1) ? res1 : res0;
    assign obs_tag   = (sel == 1) ? tg1 : tg0;

    mdu_iter #(.XLEN(64), .MUL_SEQ(1), .TAG_W(5)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_ready(ir0),
        .in_op(in_op), .in_src1(src1), .in_src2(src2), .in_tag(in_tag),
        .out_valid(ov0), .out_ready(or0), .out_result(res0), .out_tag(tg0), .busy(bz0));

    mdu_iter #(.XLEN(64), .MUL_SEQ(0), .TAG_W(5)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .in_op(in_op), .in_src1(src1), .in_src2(src2), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(or1), .out_result(res1), .out_tag(tg1), .busy(bz1));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // RISC-V M-extension results computed with plain wide arithmetic.
    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] p;
        logic [127:0]        u;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         a32, b32;
        logic                ovf, ovf32;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        ovf   = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        case (op)
            4'd0: return a * b;
            4'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
            4'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return p[127:64]; end
            4'd3: begin u = {64'd0, a} * {64'd0, b}; return u[127:64]; end
            4'd4: begin
                if (b == 0) return '1;
                if (ovf) return a;
                return sa / sb;
            end
            4'd5: begin
                if (b == 0) return '1;
                return a / b;
            end
            4'd6: begin
                if (b == 0) return a;
                if (ovf) return 64'd0;
                return sa % sb;
            end
            4'd7: begin
                if (b == 0) return a;
                return a % b;
            end
            4'd8: return sx32(a32 * b32);
            4'd12: begin
                if (b32 == 0) return '1;
                if (ovf32) return sx32(a32);
                return sx32(sa32 / sb32);
            end
            4'd13: begin
                if (b32 == 0) return '1;
                return sx32(a32 / b32);
            end
            4'd14: begin
                if (b32 == 0) return sx32(a32);
                if (ovf32) return 64'd0;
                return sx32(sa32 % sb32);
            end
            4'd15: begin
                if (b32 == 0) return sx32(a32);
                return sx32(a32 % b32);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Cycles from the accept cycle to the first cycle with out_valid high.
    function automatic int unsigned ref_lat(input int unsigned s, input logic [3:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic w, sgn;
        w = op[3];
        if (op inside {4'd9, 4'd10, 4'd11}) return 1;
        if (op[2]) begin
            sgn = !op[0];
            if (w && (b[31:0] == 0)) return 1;
            if (!w && (b == 0)) return 1;
            if (sgn && w && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF)) return 1;
            if (sgn && !w && (a == 64'h8000_0000_0000_0000) && (b == '1)) return 1;
            return w ? 33 : 65;
        end
        if (s == 1) return 2;
        return w ? 33 : 65;
    endfunction

    task automatic do_op(input int unsigned s, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input int unsigned hold);
        logic [63:0] exp;
        int unsigned explat, cyc;
        string       nm;
        nm     = $sformatf("dut%0d op%0d", s, op);
        exp    = ref_model(op, a, b);
        explat = ref_lat(s, op, a, b);
        @(negedge clk);
        sel = s; in_op = op; src1 = a; src2 = b; in_tag = tag; in_valid = 1'b1;
        #1;
        chk({nm, " in_ready"}, 64'(obs_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
        cyc = 1;
        while (!obs_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(explat));
        chk({nm, " result"}, obs_res, exp);
        chk({nm, " tag"}, 64'(obs_tag), 64'(tag));
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, 64'(obs_valid), 64'd1);
            chk({nm, " hold result"}, obs_res, exp);
            chk({nm, " hold tag"}, 64'(obs_tag), 64'(tag));
            chk({nm, " hold in_ready"}, 64'(obs_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " post valid"}, 64'(obs_valid), 64'd0);
        chk({nm, " post in_ready"}, 64'(obs_ready), 64'd1);
    endtask

    function automatic logic [63:0] rnd_opnd();
        int unsigned k;
        logic [63:0] v;
        k = $urandom_range(0, 7);
        case (k)
            0: v = '0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'hFFFF_FFFF_8000_0000;
            4: v = 64'($urandom_range(1, 40));
            5: v = -64'($urandom_range(1, 40));
            6: v = {32'd0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic seen;
        #1 rst = 1'b1;
        #1;
        for (int unsigned s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("reset out_valid", 64'(obs_valid), 64'd0);
            chk("reset out_result", obs_res, 64'd0);
            chk("reset out_tag", 64'(obs_tag), 64'd0);
            chk("reset busy", 64'(obs_busy), 64'd0);
            chk("reset in_ready", 64'(obs_ready), 64'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed cases on the iterative-multiply instance.
        do_op(0, 4'd5, 64'd100, 64'd7, 5'd1, 0);
        do_op(0, 4'd7, 64'd100, 64'd7, 5'd2, 0);
        do_op(0, 4'd4, 64'h8000_0000_0000_0000, '1, 5'd3, 0);
        do_op(0, 4'd6, 64'h8000_0000_0000_0000, '1, 5'd4, 0);
        do_op(0, 4'd5, 64'h1234, 64'd0, 5'd5, 0);
        do_op(0, 4'd7, 64'h1234, 64'd0, 5'd6, 0);
        do_op(0, 4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 0);
        do_op(0, 4'd1, '1, '1, 5'd8, 0);
        do_op(0, 4'd2, '1, '1, 5'd9, 0);
        do_op(0, 4'd8, 64'h7FFF_FFFF, 64'd2, 5'd10, 0);
        do_op(0, 4'd13, 64'hFFFF_FFFF, 64'd1, 5'd11, 0);
        do_op(0, 4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd12, 0);
        do_op(0, 4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, 0);
        do_op(0, 4'd10, 64'd5, 64'd6, 5'd14, 0);
        // Backpressure with tag 17.
        do_op(0, 4'd4, -64'd1000, 64'd7, 5'd17, 5);

        // Same multiplies on the single-cycle-multiply instance.
        do_op(1, 4'd1, '1, '1, 5'd20, 0);
        do_op(1, 4'd2, '1, '1, 5'd21, 0);
        do_op(1, 4'd8, 64'h7FFF_FFFF, 64'd2, 5'd22, 0);
        do_op(1, 4'd3, '1, 64'd3, 5'd23, 1);
        do_op(1, 4'd0, 64'd3, 64'd4, 5'd24, 0);

        // Flush at iteration 10 of a DIV.
        sel = 0;
        @(negedge clk);
        in_op = 4'd4; src1 = 64'd1000; src2 = 64'd7; in_tag = 5'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(obs_busy), 64'd0);
        chk("flush out_valid", 64'(obs_valid), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (obs_valid) seen = 1'b1;
        end
        chk("flush no late valid", 64'(seen), 64'd0);

        // Flush and request together in IDLE: nothing accepted.
        in_op = 4'd0; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush vs accept busy", 64'(obs_busy), 64'd0);
        do_op(0, 4'd0, 64'd3, 64'd4, 5'd25, 0);

        // Reset in the middle of CALC.
        @(negedge clk);
        in_op = 4'd4; src1 = 64'd12345; src2 = 64'd3; in_tag = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset busy", 64'(obs_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midreset busy", 64'(obs_busy), 64'd0);
        chk("midreset out_valid", 64'(obs_valid), 64'd0);
        chk("midreset out_result", obs_res, 64'd0);
        chk("midreset out_tag", 64'(obs_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random ops on both instances.
        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, 1), 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(),
                  5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle RV64M multiply/divide unit.
- Sits beside the combinational integer ALU in the execute stage and takes over every MUL/DIV/REM variant, including the W forms.
- Uses an iterative shift-add multiplier and a restoring radix-2 divider behind a valid/ready handshake.
- Follows full RISC-V semantics for divide-by-zero and signed overflow; results are sign-extended correctly.

Parameters:
- XLEN, 64: operand and result width. Legal values are 32 and 64; W ops exist only when XLEN=64.
- MUL_SEQ, 1: 1 = iterative multiply taking XLEN (W: 32) iterations; 0 = single-cycle multiply (one CALC cycle).
- TAG_W, 5: width of the sideband tag (destination register index) carried with each op.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of any in-flight or held op.
- in_valid  in  1  op request.
- in_ready  out  1  unit can accept an op.
- in_op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; 9-11 illegal.
- in_src1  in  XLEN  rs1 operand.
- in_src2  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid && in_ready && !flush; operands, op and tag are registered at that edge (edge t).
  - Normal case: goes to CALC.
  - Bypass case: goes directly to DONE at edge t with the final result. Bypass applies to div/rem by zero, signed overflow (most-negative / -1, 64-bit or W) and illegal op.
- CALC:
  - K iterations, one per cycle. K = XLEN for 64-bit ops, 32 for W ops, 1 for any multiply when MUL_SEQ=0.
  - The last iteration edge (t+K) applies sign correction and moves to DONE.
  - out_valid is first high in the cycle after edge t+K.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; out_result and out_tag are stable until handshake.
  - On out_valid && out_ready, returns to IDLE at that edge.
  - in_ready=0 in DONE (no same-cycle reaccept).
  - Minimum issue interval is K+2 cycles.
- flush: at the next edge in any state go to IDLE and set out_valid=0; the op is discarded. If flush and in_valid coincide in IDLE, flush wins and nothing is accepted. Flush in the same cycle as an out handshake in DONE: handshake counts, state goes to IDLE.
- Reset mid-CALC or mid-DONE: immediate IDLE, result lost.
- Signed handling: operate on magnitudes, negate result when signs differ.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - MUL: low XLEN bits of the 2*XLEN product. MULH/MULHSU/MULHU: high XLEN bits.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow: quotient = dividend; remainder = 0.
- W ops:
  - Use in_src1[31:0] and in_src2[31:0] only; compute the 32-bit result.
  - out_result = sign-extension of result bit 31, also for DIVUW/REMUW.
  - W special-case detection uses the 32-bit values only.
- Illegal op: out_result=0 via the bypass path; no error flag.
- in_src1/in_src2 may change after acceptance without affecting the result.

Test Plan:
- DIVU 100 / 7, XLEN=64: result 14; out_valid first high 65 cycles after accept. REMU same operands: result 2.
- DIV src1=0x8000000000000000, src2=0xFFFFFFFFFFFFFFFF: bypass, result 0x8000000000000000 one cycle after accept. REM same operands: result 0.
- DIVU x/0 with x=0x1234: result 0xFFFFFFFFFFFFFFFF. REMU x/0: result 0x1234. REM -7 / 2: result 0xFFFFFFFFFFFFFFFF (-1).
- MULH -1*-1: result 0. MULHSU src1=-1, src2=0xFFFFFFFFFFFFFFFF: result 0xFFFFFFFFFFFFFFFF. MULW 0x7FFFFFFF*2: result 0xFFFFFFFFFFFFFFFE. DIVUW 0xFFFFFFFF / 1: result 0xFFFFFFFFFFFFFFFF. Repeat the multiply cases with MUL_SEQ=0: one CALC cycle.
- Backpressure and tag: DIV with tag 5'd17, out_ready held low 5 cycles. out_valid, out_result and out_tag stay stable and in_ready stays 0. Next op is accepted only after the handshake.
- flush at iteration 10 of a DIV: IDLE next edge, no out_valid. Then a new MUL 3*4 returns 12. Assert rst mid-CALC: outputs go to 0 immediately.
